// File: rtl/audio_pkg.sv
// Shared types and helpers for the PCM playback engine.
package audio_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, READ, COMMIT} pcm_state_e;

    // Largest frame: 8 channels of 16-bit samples.
    localparam int MAX_FRAME_BYTES = 16;

    function automatic logic [4:0] byte_count(input logic m16, input logic [2:0] ch);
        logic [4:0] n;
        n = {2'b00, ch} + 5'd1;
        return m16 ? {n[3:0], 1'b0} : n;
    endfunction

endpackage

// File: rtl/pcm_byte_fifo.sv
// Single-clock byte FIFO with registered level counter and one-cycle read latency.
module pcm_byte_fifo #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [7:0]          wr_data,
    input  logic                rd_en,
    output logic [7:0]          rd_data_p1,
    output logic [DEPTH_LOG2:0] level,
    output logic                full
);

    logic [7:0]            mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  empty;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full  = level[DEPTH_LOG2];
    assign empty = (level == '0);
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage and read port carry no reset; only pointers and level are control.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
        if (rd_ok) rd_data_p1 <= mem[rd_ptr];
    end

endmodule

// File: rtl/pcm_stream_player.sv
// PCM playback engine: byte FIFO, phase-accumulator rate divider and frame unpacker.
module pcm_stream_player
    import audio_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int NUM_CH     = 2,
    parameter int SAMPLE_W   = 16,
    parameter int RATE_W     = 8,
    parameter int AE_LEVEL   = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_reset,
    input  logic [7:0]                 fifo_wrdata,
    input  logic                       fifo_write,
    output logic                       fifo_full,
    output logic                       fifo_almost_empty,
    output logic [DEPTH_LOG2:0]        fifo_level,
    input  logic [RATE_W-1:0]          sample_rate,
    input  logic                       mode_16bit,
    input  logic [2:0]                 mode_ch,
    input  logic                       next_sample,
    output logic [NUM_CH*SAMPLE_W-1:0] pcm_data,
    output logic                       pcm_valid,
    output logic                       underrun,
    output logic                       overflow,
    input  logic                       flag_clr
);

    localparam int LW = DEPTH_LOG2 + 1;
    localparam logic [RATE_W-1:0] RATE_FULL = {1'b1, {(RATE_W-1){1'b0}}};

    function automatic logic [RATE_W-1:0] clamp_rate(input logic [RATE_W-1:0] r);
        return (r > RATE_FULL) ? RATE_FULL : r;
    endfunction

    function automatic logic [2:0] clamp_ch(input logic [2:0] ch);
        return (int'(ch) > NUM_CH - 1) ? 3'(NUM_CH - 1) : ch;
    endfunction

    pcm_state_e          state;
    logic [RATE_W-2:0]   acc;
    logic [RATE_W-1:0]   rate_sum;
    logic                req;
    logic                pending;
    logic                m16_lat;
    logic [2:0]          ch_lat;
    logic [4:0]          nbytes;
    logic [4:0]          pop_cnt;
    logic [4:0]          cap_idx;
    logic                pop;
    logic                vld_p1;
    logic                under_hit;
    logic [7:0]          rd_data_p1;
    logic [7:0]          frame_buf [MAX_FRAME_BYTES];
    logic [7:0]          bytes_now [MAX_FRAME_BYTES];
    logic [NUM_CH*SAMPLE_W-1:0] pcm_next;

    pcm_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (fifo_reset),
        .wr_en      (fifo_write),
        .wr_data    (fifo_wrdata),
        .rd_en      (pop),
        .rd_data_p1 (rd_data_p1),
        .level      (fifo_level),
        .full       (fifo_full)
    );

    assign fifo_almost_empty = (fifo_level < LW'(AE_LEVEL));
    assign rate_sum  = {1'b0, acc} + clamp_rate(sample_rate);
    assign req       = next_sample & rate_sum[RATE_W-1];
    assign pop       = (state == READ);
    assign under_hit = (state == CHECK) && (fifo_level < LW'(nbytes));

    // The final byte is still on the FIFO read port when COMMIT assembles the frame.
    always_comb begin
        for (int i = 0; i < MAX_FRAME_BYTES; i++)
            bytes_now[i] = (vld_p1 && int'(cap_idx) == i) ? rd_data_p1 : frame_buf[i];
    end

    always_comb begin
        logic signed [15:0]       smp16;
        logic signed [SAMPLE_W-1:0] smp;
        int                       src;
        pcm_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            src   = (ch_lat == 3'd0) ? 0 : c;
            smp16 = m16_lat ? {bytes_now[2*src+1], bytes_now[2*src]} : {bytes_now[src], 8'h00};
            smp   = SAMPLE_W'(smp16) << (SAMPLE_W - 16);
            if (ch_lat == 3'd0 || c <= int'(ch_lat))
                pcm_next[c*SAMPLE_W +: SAMPLE_W] = smp;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) frame_buf[cap_idx[3:0]] <= rd_data_p1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            pending   <= 1'b0;
            m16_lat   <= 1'b0;
            ch_lat    <= '0;
            nbytes    <= '0;
            pop_cnt   <= '0;
            cap_idx   <= '0;
            vld_p1    <= 1'b0;
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
        end else if (fifo_reset) begin
            state     <= IDLE;
            acc       <= '0;
            pending   <= 1'b0;
            pop_cnt   <= '0;
            cap_idx   <= '0;
            vld_p1    <= 1'b0;
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            vld_p1    <= pop;
            if (next_sample) acc <= rate_sum[RATE_W-2:0];
            pending  <= req | (pending & (state != IDLE));
            underrun <= (underrun & ~flag_clr) | under_hit;
            overflow <= (overflow & ~flag_clr) | (fifo_write & fifo_full);
            if (vld_p1) cap_idx <= cap_idx + 5'd1;
            case (state)
                IDLE: begin
                    if (pending) begin
                        m16_lat <= mode_16bit;
                        ch_lat  <= clamp_ch(mode_ch);
                        nbytes  <= byte_count(mode_16bit, clamp_ch(mode_ch));
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    pop_cnt <= '0;
                    cap_idx <= '0;
                    if (under_hit) begin
                        pcm_data  <= '0;
                        pcm_valid <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state <= READ;
                    end
                end
                READ: begin
                    pop_cnt <= pop_cnt + 5'd1;
                    if (pop_cnt == nbytes - 5'd1) state <= COMMIT;
                end
                COMMIT: begin
                    pcm_data  <= pcm_next;
                    pcm_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_stream_player.sv
// Directed bench for pcm_stream_player: playback, rate, unpack, underrun/overflow, resets.
module tb_pcm_stream_player;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_reset;
    logic [7:0]  fifo_wrdata;
    logic        fifo_write;
    logic        fifo_full;
    logic        fifo_almost_empty;
    logic [12:0] fifo_level;
    logic [7:0]  sample_rate;
    logic        mode_16bit;
    logic [2:0]  mode_ch;
    logic        next_sample;
    logic [31:0] pcm_data;
    logic        pcm_valid;
    logic        underrun;
    logic        overflow;
    logic        flag_clr;

    int checks = 0;
    int errors = 0;
    int nval;
    int lat;
    logic [31:0] last_data;

    pcm_stream_player dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fifo_reset        (fifo_reset),
        .fifo_wrdata       (fifo_wrdata),
        .fifo_write        (fifo_write),
        .fifo_full         (fifo_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_level        (fifo_level),
        .sample_rate       (sample_rate),
        .mode_16bit        (mode_16bit),
        .mode_ch           (mode_ch),
        .next_sample       (next_sample),
        .pcm_data          (pcm_data),
        .pcm_valid         (pcm_valid),
        .underrun          (underrun),
        .overflow          (overflow),
        .flag_clr          (flag_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_byte(input logic [7:0] b);
        fifo_wrdata = b;
        fifo_write  = 1'b1;
        tick();
        fifo_write  = 1'b0;
    endtask

    // One strobe, then watch a bounded window for pcm_valid pulses.
    task automatic run_strobe(output int nv, output int first);
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        nv = 0;
        first = -1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (pcm_valid) begin
                nv++;
                if (first < 0) first = n;
                last_data = pcm_data;
            end
        end
    endtask

    function automatic logic [31:0] stereo_frame(input int k);
        return {16'(2*k+1), 16'(2*k)};
    endfunction

    initial begin
        rst_n = 1'b0; fifo_reset = 1'b0; fifo_wrdata = '0; fifo_write = 1'b0;
        sample_rate = 8'd128; mode_16bit = 1'b1; mode_ch = 3'd1;
        next_sample = 1'b0; flag_clr = 1'b0; last_data = '0;
        repeat (3) tick();
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_ae", 64'(fifo_almost_empty), 64'd1);
        chk("rst_full", 64'(fifo_full), 64'd0);
        chk("rst_pcm", 64'(pcm_data), 64'd0);
        chk("rst_valid", 64'(pcm_valid), 64'd0);
        chk("rst_flags", 64'({underrun, overflow}), 64'd0);
        rst_n = 1'b1;
        tick();

        // 600 little-endian 16-bit words i.
        for (int i = 0; i < 600; i++) begin
            wr_byte(8'(i));
            wr_byte(8'(i >> 8));
        end
        chk("fill_level", 64'(fifo_level), 64'd1200);
        chk("fill_ae", 64'(fifo_almost_empty), 64'd0);

        for (int k = 0; k < 4; k++) begin
            run_strobe(nval, lat);
            chk($sformatf("r128_nval%0d", k), 64'(nval), 64'd1);
            chk($sformatf("r128_lat%0d", k), 64'(lat), 64'd7);
            chk($sformatf("r128_data%0d", k), 64'(last_data), 64'(stereo_frame(k)));
        end

        sample_rate = 8'd64;
        for (int k = 4; k < 6; k++) begin
            run_strobe(nval, lat);
            chk($sformatf("r64_skip%0d", k), 64'(nval), 64'd0);
            run_strobe(nval, lat);
            chk($sformatf("r64_nval%0d", k), 64'(nval), 64'd1);
            chk($sformatf("r64_data%0d", k), 64'(last_data), 64'(stereo_frame(k)));
        end

        sample_rate = 8'd0;
        begin
            int tot;
            tot = 0;
            for (int s = 0; s < 10; s++) begin
                run_strobe(nval, lat);
                tot += nval;
            end
            chk("r0_nval", 64'(tot), 64'd0);
            chk("r0_hold", 64'(pcm_data), 64'(stereo_frame(5)));
        end

        sample_rate = 8'd200;
        run_strobe(nval, lat);
        chk("rclamp_nval", 64'(nval), 64'd1);
        chk("rclamp_data", 64'(last_data), 64'(stereo_frame(6)));
        chk("play_level", 64'(fifo_level), 64'd1172);

        fifo_reset = 1'b1; tick(); fifo_reset = 1'b0;
        chk("frst_level", 64'(fifo_level), 64'd0);

        // Mono 8-bit replication and left-justification.
        sample_rate = 8'd128; mode_16bit = 1'b0; mode_ch = 3'd0;
        wr_byte(8'h80);
        wr_byte(8'h7F);
        run_strobe(nval, lat);
        chk("mono_lat", 64'(lat), 64'd4);
        chk("mono_d0", 64'(last_data), 64'h8000_8000);
        run_strobe(nval, lat);
        chk("mono_d1", 64'(last_data), 64'h7F00_7F00);

        // Underrun with 3 bytes for a 4-byte frame.
        mode_16bit = 1'b1; mode_ch = 3'd1;
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
        run_strobe(nval, lat);
        chk("und_nval", 64'(nval), 64'd1);
        chk("und_flag", 64'(underrun), 64'd1);
        chk("und_data", 64'(last_data), 64'd0);
        chk("und_level", 64'(fifo_level), 64'd3);
        flag_clr = 1'b1; tick(); flag_clr = 1'b0;
        chk("und_clr", 64'(underrun), 64'd0);

        // Fill to capacity, then overflow.
        fifo_reset = 1'b1; tick(); fifo_reset = 1'b0;
        for (int i = 0; i < 4096; i++) wr_byte(8'(i));
        chk("full_flag", 64'(fifo_full), 64'd1);
        chk("full_level", 64'(fifo_level), 64'd4096);
        chk("full_noovf", 64'(overflow), 64'd0);
        wr_byte(8'hEE);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_level", 64'(fifo_level), 64'd4096);
        chk("ovf_full", 64'(fifo_full), 64'd1);
        flag_clr = 1'b1; tick(); flag_clr = 1'b0;
        chk("ovf_clr", 64'(overflow), 64'd0);

        mode_16bit = 1'b0; mode_ch = 3'd0;
        run_strobe(nval, lat);
        chk("pop1_data", 64'(last_data), 64'h0000_0000);
        chk("pop1_level", 64'(fifo_level), 64'd4095);

        // Write on the same edge as the single pop of a 1-byte frame.
        next_sample = 1'b1; tick(); next_sample = 1'b0;
        tick(); tick();
        fifo_wrdata = 8'hAA; fifo_write = 1'b1; tick(); fifo_write = 1'b0;
        tick();
        chk("wp_valid", 64'(pcm_valid), 64'd1);
        chk("wp_data", 64'(pcm_data), 64'h0100_0100);
        chk("wp_level", 64'(fifo_level), 64'd4095);

        // fifo_reset in the middle of READ.
        mode_16bit = 1'b1; mode_ch = 3'd1;
        next_sample = 1'b1; tick(); next_sample = 1'b0;
        tick(); tick(); tick();
        fifo_reset = 1'b1; tick(); fifo_reset = 1'b0;
        nval = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (pcm_valid) nval++;
        end
        chk("fra_nval", 64'(nval), 64'd0);
        chk("fra_level", 64'(fifo_level), 64'd0);
        chk("fra_ae", 64'(fifo_almost_empty), 64'd1);

        // Asynchronous reset mid-operation.
        wr_byte(8'h34); wr_byte(8'h12); wr_byte(8'h78); wr_byte(8'h56);
        wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03);
        run_strobe(nval, lat);
        chk("ar_pre_data", 64'(last_data), 64'h5678_1234);
        mode_16bit = 1'b0; mode_ch = 3'd0;
        next_sample = 1'b1; tick(); next_sample = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_level", 64'(fifo_level), 64'd0);
        chk("ar_pcm", 64'(pcm_data), 64'd0);
        chk("ar_valid", 64'(pcm_valid), 64'd0);
        chk("ar_ae_full", 64'({fifo_almost_empty, fifo_full}), 64'b10);
        tick();
        rst_n = 1'b1;
        tick();
        run_strobe(nval, lat);
        chk("ar_post_und", 64'(underrun), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
